// File: rtl/cache_fill_fsm_pkg.sv
// rtl/cache_fill_fsm_pkg.sv - shared types and constants for the cache block fill FSM
//
// Purpose: state encoding and block geometry shared by the fill FSM, its
// interface and its counters.
// Ports: none (package).
package cache_fill_fsm_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

  localparam int BLOCK_BYTES         = 16;
  localparam int WORD_BYTES          = 2;
  localparam int DEF_WORDS_PER_BLOCK = BLOCK_BYTES / WORD_BYTES;
  localparam int OFFSET_W            = $clog2(DEF_WORDS_PER_BLOCK);

endpackage

// File: rtl/cache_fill_fsm_if.sv
// rtl/cache_fill_fsm_if.sv - cache/memory/array signal bundle for the fill FSM
//
// Purpose: groups the miss request, memory read port and array write port.
// Ports (master = fill FSM side):
//   in : miss_detected, miss_address, memory_data_valid, memory_data
//   out: fsm_busy, mem_enable, memory_address, write_data_array, word_offset,
//        data_to_array, write_tag_array, block_base
interface cache_fill_fsm_if
  import cache_fill_fsm_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int OFF_W      = OFFSET_W
);

  logic                  miss_detected;
  logic [ADDR_WIDTH-1:0] miss_address;
  logic                  memory_data_valid;
  logic [15:0]           memory_data;
  logic                  fsm_busy;
  logic                  mem_enable;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic                  write_data_array;
  logic [OFF_W-1:0]      word_offset;
  logic [15:0]           data_to_array;
  logic                  write_tag_array;
  logic [ADDR_WIDTH-1:0] block_base;

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, mem_enable, memory_address, write_data_array,
           word_offset, data_to_array, write_tag_array, block_base
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, mem_enable, memory_address, write_data_array,
           word_offset, data_to_array, write_tag_array, block_base
  );

endinterface

// File: rtl/cache_fill_fsm_fill_counter.sv
// rtl/cache_fill_fsm_fill_counter.sv - clearable enabled up-counter with terminal count
//
// Purpose: counts issued requests or received words within one block fill.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : synchronous clear (wins over en_i)
//   en_i     : increment enable
//   cnt_o    : current count
//   tc_o     : count equals TC
module cache_fill_fsm_fill_counter
  import cache_fill_fsm_pkg::*;
#(
  parameter int          W  = 4,
  parameter int unsigned TC = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == W'(TC));

endmodule

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - L1 miss handler that fills one block from word memory
//
// Purpose: on a miss, issues one read per word of the block, writes returned
// words into the data array by offset, and writes the tag with the last word.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : cache_fill_fsm_if.master (miss in, memory request/return,
//              data/tag array writes, fsm_busy stall, block_base)
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  cache_fill_fsm_if.master bus
);

  localparam int OFF_W   = $clog2(WORDS_PER_BLOCK);
  // One extra bit so the request counter can sit at WORDS_PER_BLOCK.
  localparam int CNT_W   = OFF_W + 1;
  localparam int ALIGN_W = $clog2(2 * WORDS_PER_BLOCK);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << ALIGN_W) - ADDR_WIDTH'(1));

  localparam logic [0:0] S_IDLE = ST_IDLE;
  localparam logic [0:0] S_FILL = ST_FILL;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] block_base_q, block_base_d;
  logic [CNT_W-1:0]      req_cnt, rcv_cnt;
  logic                  req_done, rcv_last;
  logic                  in_fill, start_fill, req_en, rcv_en, last_word;
  logic [ADDR_WIDTH-1:0] req_offset;
  logic                  unused_rcv_msb;

  assign in_fill    = (state_q == S_FILL);
  assign start_fill = (state_q == S_IDLE) && bus.miss_detected;
  assign req_en     = in_fill && !req_done;
  assign rcv_en     = in_fill && bus.memory_data_valid;
  assign last_word  = rcv_en && rcv_last;

  cache_fill_fsm_fill_counter #(
    .W  (CNT_W),
    .TC (WORDS_PER_BLOCK)
  ) u_req_counter (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start_fill),
    .en_i  (req_en),
    .cnt_o (req_cnt),
    .tc_o  (req_done)
  );

  // Terminal count at the last offset flags the word that completes the block.
  cache_fill_fsm_fill_counter #(
    .W  (CNT_W),
    .TC (WORDS_PER_BLOCK - 1)
  ) u_rcv_counter (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start_fill),
    .en_i  (rcv_en),
    .cnt_o (rcv_cnt),
    .tc_o  (rcv_last)
  );

  // Only the offset bits of the receive count address the array.
  assign unused_rcv_msb = rcv_cnt[CNT_W-1];

  always_comb begin
    state_d      = state_q;
    block_base_d = block_base_q;
    if (start_fill) begin
      state_d      = S_FILL;
      block_base_d = bus.miss_address & ALIGN_MASK;
    end else if (last_word) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      block_base_q <= '0;
    end else begin
      state_q      <= state_d;
      block_base_q <= block_base_d;
    end
  end

  assign req_offset = ADDR_WIDTH'(req_cnt) * ADDR_WIDTH'(WORD_BYTES);

  assign bus.fsm_busy         = in_fill;
  assign bus.mem_enable       = req_en;
  assign bus.memory_address   = req_en ? (block_base_q + req_offset) : '0;
  // Array writes follow the returned data in the same cycle; outputs are
  // held at zero whenever no write is taking place.
  assign bus.write_data_array = rcv_en;
  assign bus.word_offset      = rcv_en ? rcv_cnt[OFF_W-1:0] : '0;
  assign bus.data_to_array    = rcv_en ? bus.memory_data : '0;
  assign bus.write_tag_array  = last_word;
  assign bus.block_base       = block_base_q;

endmodule
